trace_buf_ctrl: RTL and testbench
=================================

Name: trace_buf_ctrl

Overview:
Controller for the on-chip branch-trace RAM. It takes branch events from the PC-change detector and writes the branch-target PC into a single-port trace RAM as a circular or stop-on-full buffer. It also arbitrates that same RAM port with debugger read requests coming from the DM register interface. It sits between the branch detector, the trace RAM macro and the debug module's trace CSRs.

Parameters:
AW, 6, trace RAM address width; DEPTH = 2**AW entries
PC_W, 32, PC / RAM data width
STARVE_MAX, 4, consecutive read deferrals before the read wins the RAM port

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
trace_en  in  1  capture enable (DM CSR)
trace_clr  in  1  one-cycle pulse; clears buffer state
stop_on_full  in  1  1 = stop capturing when full; 0 = wrap and overwrite oldest
br_valid  in  1  branch event (strobe from branch detector)
br_pc  in  PC_W  PC to record, valid with br_valid
rd_req  in  1  debugger read request; held until rd_ack
rd_idx  in  AW  logical index; 0 = oldest valid entry
rd_ack  out  1  one-cycle pulse; rd_data/rd_err valid
rd_data  out  PC_W  read result, registered
rd_err  out  1  read index out of range, or read aborted by clear
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable (only with ram_en)
ram_addr  out  AW  RAM address
ram_wdata  out  PC_W  RAM write data
ram_rdata  in  PC_W  RAM read data; 1-cycle latency after ram_en & !ram_we
count  out  AW+1  valid entries, saturates at DEPTH
full  out  1  count == DEPTH
wrapped  out  1  sticky; set on the first overwrite in wrap mode
drop_cnt  out  8  saturating count of dropped branch events

Behaviour:
- Reset (async, rst_n low): all outputs 0. wr_ptr=0, starve=0, read FSM = IDLE.
- Write attempt condition: br_valid & trace_en & !trace_clr.
- A write attempt is dropped if full & stop_on_full. Dropped events increment drop_cnt, which saturates at 255.
- A write attempt is also dropped if the read FSM holds the port in its forced slot (see PEND). These drops also increment drop_cnt.
- Otherwise the attempt is an accepted write in the same cycle: ram_en=1, ram_we=1, ram_addr=wr_ptr, ram_wdata=br_pc. All RAM outputs are combinational.
- On an accepted write, wr_ptr increments modulo DEPTH. count increments unless it is already DEPTH.
- If an accepted write happens while full (wrap mode), wrapped is set.
- trace_clr has priority over everything: wr_ptr, count, wrapped and drop_cnt clear next cycle. A write in the clear cycle is discarded and not counted.
- Oldest-entry physical address: base = wrapped_or_full ? wr_ptr : 0. The read address is (base + rd_idx) mod DEPTH.
- Read FSM states: IDLE, PEND, DATA, RESP.
- IDLE: on rd_req, latch rd_idx and go to PEND.
  - If rd_idx >= count, skip the RAM: go to RESP with err=1, data=0.
- PEND:
  - If trace_clr: go to RESP with err=1.
  - Else, if there is no write attempt this cycle, or starve == STARVE_MAX: drive the read (ram_en=1, ram_we=0, ram_addr = computed address) and go to DATA. If a write attempt occurs in that forced cycle, it is dropped.
  - Else: stay in PEND and increment starve.
  - starve clears on leaving PEND.
- DATA: register ram_rdata into rd_data with err=0, then go to RESP. A clear in this cycle does not abort the read.
- RESP: rd_ack=1 for one cycle, then go to IDLE. rd_req is not resampled until IDLE.
- Latency: minimum 3 cycles from rd_req to rd_ack (IDLE, PEND, DATA, ack in RESP). Out-of-range reads ack after 2 cycles.
- ram_en is never asserted for both a write and a read in the same cycle.
- rd_data and rd_err hold their values until the next rd_ack.

Decomposition:
- Package trace_pkg holds:
  - rd_state_e enum (IDLE/PEND/DATA/RESP)
  - default AW/PC_W localparams
  - a shared trace_cfg_t struct {en, clr, stop_on_full}, also used by the DM CSR block
- The read-arbitration FSM is natural as sub-module trace_rd_arb. It owns the starve counter and the address computation; the top level keeps the pointer/count logic.

Test Plan:
- Wrap mode, AW=2: 6 branches with pc 0x100..0x105 → count=4, full=1, wrapped=1. Reads idx0..3 return 0x102,0x103,0x104,0x105 with rd_err=0.
- stop_on_full=1, AW=2: 6 branches → count=4, wrapped=0, drop_cnt=2. Read idx0 returns the first pc.
- rd_req idx=3 with count=2 → rd_ack after 2 cycles, rd_err=1, rd_data=0, no ram_en read cycle.
- Continuous br_valid with a rd_req pending → read is issued on the 5th PEND cycle (STARVE_MAX=4). drop_cnt increments by 1. rd_ack returns the correct data.
- trace_clr together with br_valid while the FSM is in PEND → next cycle count=0, drop_cnt=0. Then rd_ack with rd_err=1. The clear-cycle branch is not written.
- rst_n asserted mid-read (in DATA) → all outputs 0 immediately. After release, the FSM is IDLE and no spurious rd_ack occurs.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: shared types and defaults for the branch-trace buffer
package trace_pkg;
  localparam int AW_DEF = 6;
  localparam int PC_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, PEND, DATA, RESP} rd_state_e;
  typedef struct packed {
    logic en;
    logic clr;
    logic stop_on_full;
  } trace_cfg_t;
endpackage

// File: rtl/trace_rd_arb.sv
// trace_rd_arb: debugger read FSM sharing the trace RAM port with branch writes
module trace_rd_arb
  import trace_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PC_W = PC_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            wr_att,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_idx,
  input  logic [AW:0]     count,
  input  logic [AW-1:0]   base,
  input  logic [PC_W-1:0] ram_rdata,
  output logic            rd_go,
  output logic [AW-1:0]   rd_addr,
  output logic            rd_ack,
  output logic [PC_W-1:0] rd_data,
  output logic            rd_err
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  rd_state_e state;
  logic [AW-1:0] idx;
  logic [SW-1:0] starve;
  logic oor;
  assign oor = {1'b0, idx} >= count;
  assign rd_addr = base + idx;
  // The read takes the port when no write competes, or once it has been deferred STARVE_MAX times
  assign rd_go = state == PEND && !clr && !oor && (!wr_att || starve == SW'(STARVE_MAX));
  // Read sequencing; result registers only change on entry to RESP so they hold between acks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      starve <= '0;
      rd_ack <= 1'b0;
      rd_data <= '0;
      rd_err <= 1'b0;
    end else begin
      rd_ack <= 1'b0;
      case (state)
        IDLE: if (rd_req) begin
          idx <= rd_idx;
          state <= PEND;
        end
        PEND: if (clr || oor) begin
          state <= RESP;
          rd_ack <= 1'b1;
          rd_err <= 1'b1;
          rd_data <= '0;
          starve <= '0;
        end else if (rd_go) begin
          state <= DATA;
          starve <= '0;
        end else starve <= starve + 1'b1;
        DATA: begin
          state <= RESP;
          rd_ack <= 1'b1;
          rd_err <= 1'b0;
          rd_data <= ram_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/trace_buf_ctrl.sv
// trace_buf_ctrl: branch-trace RAM write pointer, occupancy and read arbitration
module trace_buf_ctrl
  import trace_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PC_W = PC_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trace_en,
  input  logic            trace_clr,
  input  logic            stop_on_full,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_pc,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_idx,
  output logic            rd_ack,
  output logic [PC_W-1:0] rd_data,
  output logic            rd_err,
  output logic            ram_en,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [PC_W-1:0] ram_wdata,
  input  logic [PC_W-1:0] ram_rdata,
  output logic [AW:0]     count,
  output logic            full,
  output logic            wrapped,
  output logic [7:0]      drop_cnt
);
  localparam int DEPTH = 2 ** AW;
  trace_cfg_t cfg;
  logic [AW-1:0] wr_ptr, base, rd_addr;
  logic wr_att, rd_go, drop, accept;
  assign cfg = '{en: trace_en, clr: trace_clr, stop_on_full: stop_on_full};
  assign wr_att = rst_n & br_valid & cfg.en & !cfg.clr;
  assign drop = wr_att & ((full & cfg.stop_on_full) | rd_go);
  assign accept = wr_att & !drop;
  assign full = count == (AW + 1)'(DEPTH);
  assign base = (wrapped | full) ? wr_ptr : '0;
  assign ram_en = accept | rd_go;
  assign ram_we = accept;
  assign ram_addr = rd_go ? rd_addr : accept ? wr_ptr : '0;
  assign ram_wdata = accept ? br_pc : '0;
  trace_rd_arb #(.AW(AW), .PC_W(PC_W), .STARVE_MAX(STARVE_MAX)) u_rd_arb (
    .clk(clk),
    .rst_n(rst_n),
    .clr(cfg.clr),
    .wr_att(wr_att),
    .rd_req(rd_req),
    .rd_idx(rd_idx),
    .count(count),
    .base(base),
    .ram_rdata(ram_rdata),
    .rd_go(rd_go),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_data(rd_data),
    .rd_err(rd_err)
  );
  // Write pointer, occupancy, overwrite flag and drop counter; clear overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count <= '0;
      wrapped <= 1'b0;
      drop_cnt <= '0;
    end else if (cfg.clr) begin
      wr_ptr <= '0;
      count <= '0;
      wrapped <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        count <= full ? count : count + 1'b1;
        wrapped <= wrapped | full;
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_trace_buf_ctrl.sv
// tb_trace_buf_ctrl: directed checks of trace capture, wrap/stop modes and read arbitration
module tb_trace_buf_ctrl;
  logic clk, rst_n, trace_en, trace_clr, stop_on_full, br_valid, rd_req;
  logic [31:0] br_pc, rd_data, ram_wdata, ram_rdata;
  logic [1:0] rd_idx, ram_addr;
  logic rd_ack, rd_err, ram_en, ram_we, full, wrapped;
  logic [2:0] count;
  logic [7:0] drop_cnt;
  logic [31:0] mem [4];
  int n_assert = 0;
  int n_fail = 0;
  int lat;
  logic saw, got_ack;

  trace_buf_ctrl #(.AW(2), .PC_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .trace_clr(trace_clr),
    .stop_on_full(stop_on_full), .br_valid(br_valid), .br_pc(br_pc),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_data(rd_data),
    .rd_err(rd_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .count(count), .full(full),
    .wrapped(wrapped), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic branch(input logic [31:0] pc);
    br_valid = 1'b1;
    br_pc = pc;
    tick();
    br_valid = 1'b0;
  endtask

  task automatic clear();
    trace_clr = 1'b1;
    tick();
    trace_clr = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] idx, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_lat, input logic exp_saw);
    rd_req = 1'b1;
    rd_idx = idx;
    lat = 0;
    saw = 1'b0;
    while (!rd_ack && lat < 20) begin
      #1;
      if (ram_en && !ram_we) saw = 1'b1;
      @(posedge clk);
      #1;
      lat++;
      if (br_valid) br_pc = br_pc + 1;
    end
    rd_req = 1'b0;
    br_valid = 1'b0;
    chk({tag, "_ack"}, rd_ack, 1'b1);
    chk({tag, "_data"}, rd_data, exp_data);
    chk({tag, "_err"}, rd_err, exp_err);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_ramrd"}, saw, exp_saw);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    trace_en = 1'b0;
    trace_clr = 1'b0;
    stop_on_full = 1'b0;
    br_valid = 1'b0;
    br_pc = '0;
    rd_req = 1'b0;
    rd_idx = '0;
    #2;
    chk("rst_ack", rd_ack, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_drop", drop_cnt, 0);
    tick();
    rst_n = 1'b1;
    trace_en = 1'b1;
    tick();
    // wrap mode: six branches into a four-entry buffer
    for (int i = 0; i < 6; i++) branch(32'h100 + i);
    chk("wrap_count", count, 4);
    chk("wrap_full", full, 1);
    chk("wrap_wrapped", wrapped, 1);
    chk("wrap_drop", drop_cnt, 0);
    read_chk("wrap_rd0", 2'd0, 32'h102, 1'b0, 3, 1'b1);
    read_chk("wrap_rd1", 2'd1, 32'h103, 1'b0, 3, 1'b1);
    read_chk("wrap_rd2", 2'd2, 32'h104, 1'b0, 3, 1'b1);
    read_chk("wrap_rd3", 2'd3, 32'h105, 1'b0, 3, 1'b1);
    // stop-on-full mode
    clear();
    chk("clr_count", count, 0);
    chk("clr_wrapped", wrapped, 0);
    chk("clr_full", full, 0);
    stop_on_full = 1'b1;
    for (int i = 0; i < 6; i++) branch(32'h200 + i);
    chk("stop_count", count, 4);
    chk("stop_wrapped", wrapped, 0);
    chk("stop_drop", drop_cnt, 2);
    read_chk("stop_rd0", 2'd0, 32'h200, 1'b0, 3, 1'b1);
    read_chk("stop_rd3", 2'd3, 32'h203, 1'b0, 3, 1'b1);
    // out-of-range read
    clear();
    branch(32'h300);
    branch(32'h301);
    chk("oor_count", count, 2);
    read_chk("oor_rd3", 2'd3, 32'h0, 1'b1, 2, 1'b0);
    read_chk("oor_rd1", 2'd1, 32'h301, 1'b0, 3, 1'b1);
    // starvation: continuous writes against a pending read
    stop_on_full = 1'b0;
    clear();
    for (int i = 0; i < 4; i++) branch(32'h400 + i);
    chk("starve_pre_drop", drop_cnt, 0);
    br_valid = 1'b1;
    br_pc = 32'h500;
    read_chk("starve_rd1", 2'd1, 32'h502, 1'b0, 7, 1'b1);
    chk("starve_drop", drop_cnt, 1);
    chk("starve_wrapped", wrapped, 1);
    // clear while the read is pending
    rd_req = 1'b1;
    rd_idx = 2'd0;
    br_valid = 1'b1;
    br_pc = 32'h600;
    tick();
    trace_clr = 1'b1;
    br_pc = 32'h6AA;
    #1;
    chk("clrpend_ram_en", ram_en, 0);
    tick();
    chk("clrpend_count", count, 0);
    chk("clrpend_drop", drop_cnt, 0);
    chk("clrpend_wrapped", wrapped, 0);
    chk("clrpend_ack", rd_ack, 1);
    chk("clrpend_err", rd_err, 1);
    chk("clrpend_data", rd_data, 0);
    trace_clr = 1'b0;
    br_valid = 1'b0;
    rd_req = 1'b0;
    tick();
    chk("clrpend_ack_pulse", rd_ack, 0);
    // reset during the DATA cycle of a read
    branch(32'h700);
    branch(32'h701);
    read_chk("mid_rd1", 2'd1, 32'h701, 1'b0, 3, 1'b1);
    rd_req = 1'b1;
    rd_idx = 2'd0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", rd_ack, 0);
    chk("midrst_data", rd_data, 0);
    chk("midrst_err", rd_err, 0);
    chk("midrst_count", count, 0);
    chk("midrst_ram_en", ram_en, 0);
    rd_req = 1'b0;
    tick();
    rst_n = 1'b1;
    got_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd_ack) got_ack = 1'b1;
    end
    chk("midrst_no_ack", got_ack, 0);
    chk("midrst_count_after", count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
